// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - load/store unit adding byte/halfword accesses over a word-addressed data memory
//
// Purpose: sits between the memory stage and a single-port word memory with
// combinational read and clocked write. Sub-word loads are extracted and
// sign/zero extended; sub-word stores are read-modify-write.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req, we_req, size,      request (sampled in IDLE only), store flag,
//   sign_ext, addr, wdata   00 byte / 01 half / 10 word, extension, byte address, store data
//   busy, done, misaligned  not-IDLE flag, completion pulse, rejection flag (valid with done)
//   rdata                   load result, held until the next load completes
//   mem_we, mem_a, mem_wd   data memory write enable, word address, write data
//   mem_rd                  data memory read data
module lsu_subword #(
  parameter logic BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we_req,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] wdata_q, wdata_d;
  logic        sext_q, sext_d;
  logic        mis_q, mis_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wd_q, mem_wd_d;

  logic        mis_in;
  logic [4:0]  lane_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] ins_val;
  logic [31:0] merged;

  // Rejection is decided on the live request so the access goes straight to RESP.
  assign mis_in = (size == 2'b11) ||
                  (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00);

  // Bit offset of the addressed lane(s). In big-endian order the lowest byte
  // address is the most significant, so a halfword at offset 0 sits in [31:16].
  always_comb begin
    lane_sh = 5'd0;
    if (size_q == 2'b00) begin
      lane_sh = BIG_ENDIAN ? (5'd24 - {addr_q[1:0], 3'b000}) : {addr_q[1:0], 3'b000};
    end else if (BIG_ENDIAN ? !addr_q[1] : addr_q[1]) begin
      lane_sh = 5'd16;
    end
  end

  assign ld_byte = 8'(mem_rd >> lane_sh);
  assign ld_half = 16'(mem_rd >> lane_sh);

  always_comb begin
    load_val = mem_rd;
    if (size_q == 2'b00) begin
      load_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
    end else if (size_q == 2'b01) begin
      load_val = {{16{sext_q & ld_half[15]}}, ld_half};
    end
  end

  assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
  assign ins_val   = ((size_q == 2'b00) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q}) << lane_sh;
  assign merged    = (mem_rd & ~lane_mask) | ins_val;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    sext_d   = sext_q;
    mis_d    = mis_q;
    rdata_d  = rdata_q;
    mem_wd_d = mem_wd_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          wdata_d = wdata[15:0];
          sext_d  = sign_ext;
          mis_d   = mis_in;
          if (mis_in) begin
            state_d = S_RESP;
          end else if (!we_req) begin
            state_d = S_LOAD;
          end else if (size == 2'b10) begin
            mem_wd_d = wdata;
            state_d  = S_WRITE;
          end else begin
            state_d = S_MERGE;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_val;
        state_d = S_RESP;
      end
      S_MERGE: begin
        mem_wd_d = merged;
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      wdata_q  <= 16'h0;
      sext_q   <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= 32'h0;
      mem_wd_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      sext_q   <= sext_d;
      mis_q    <= mis_d;
      rdata_q  <= rdata_d;
      mem_wd_q <= mem_wd_d;
    end
  end

  // Decoded from state alone: reset clears state_q asynchronously, so mem_we
  // drops at once and no partial write can land.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_RESP);
  assign misaligned = (state_q == S_RESP) && mis_q;
  assign mem_we     = (state_q == S_WRITE);
  assign mem_a      = {addr_q[31:2], 2'b00};
  assign mem_wd     = mem_wd_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - scoreboard bench for lsu_subword, both byte orders
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we_req = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;

  logic        busy0, done0, mis0, mem_we0, busy1, done1, mis1, mem_we1;
  logic [31:0] rdata0, mem_a0, mem_wd0, mem_rd0, rdata1, mem_a1, mem_wd1, mem_rd1;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];

  always #5 clk = ~clk;

  lsu_subword #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset_n(reset_n), .req(req0), .we_req(we_req), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy0), .done(done0),
    .misaligned(mis0), .rdata(rdata0), .mem_we(mem_we0), .mem_a(mem_a0),
    .mem_wd(mem_wd0), .mem_rd(mem_rd0));

  lsu_subword #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset_n(reset_n), .req(req1), .we_req(we_req), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy1), .done(done1),
    .misaligned(mis1), .rdata(rdata1), .mem_we(mem_we1), .mem_a(mem_a1),
    .mem_wd(mem_wd1), .mem_rd(mem_rd1));

  assign mem_rd0 = mem0[mem_a0[5:2]];
  assign mem_rd1 = mem1[mem_a1[5:2]];
  always @(posedge clk) begin
    if (mem_we0) mem0[mem_a0[5:2]] <= mem_wd0;
    if (mem_we1) mem1[mem_a1[5:2]] <= mem_wd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          we_at;   // cycle after acceptance where mem_we is high, 0 = never
    int          tacc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   sel = 1'b0;
  int   we_cnt = 0;
  int   we_lat = 0;

  wire        done_s  = sel ? done1   : done0;
  wire        mis_s   = sel ? mis1    : mis0;
  wire        mwe_s   = sel ? mem_we1 : mem_we0;
  wire [31:0] rdata_s = sel ? rdata1  : rdata0;

  // Scoreboard: each completion is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_n && mwe_s) begin
      we_cnt++;
      if (q.size() > 0) we_lat = cyc - q[0].tacc + 1;
    end
    if (reset_n && done_s) begin
      check("done_expected", {31'h0, q.size() != 0}, 32'h1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.tag, "_lat"}, cyc - e.tacc + 1, e.lat);
        check({e.tag, "_mis"}, {31'h0, mis_s}, {31'h0, e.mis});
        check({e.tag, "_rdata"}, rdata_s, e.rd);
        check({e.tag, "_we_cnt"}, we_cnt, (e.we_at != 0) ? 1 : 0);
        if (e.we_at != 0) check({e.tag, "_we_at"}, we_lat, e.we_at);
      end
      we_cnt = 0;
      we_lat = 0;
    end
  end

  task automatic drive(input bit be, input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    sel = be; we_req = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    req0 = !be; req1 = be;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check({tag, "_timeout"}, q.size(), 0);
  endtask

  task automatic issue(input string tag, input bit be, input bit w, input logic [1:0] sz,
                       input bit sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input bit emis, input int elat, input int ewe);
    @(negedge clk);
    drive(be, w, sz, sx, a, wd);
    q.push_back('{tag, erd, emis, elat, ewe, cyc + 1});
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_empty(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
    #12;
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_done", {31'h0, done0}, 32'h0);
    check("rst_mis", {31'h0, mis0}, 32'h0);
    check("rst_we", {31'h0, mem_we0}, 32'h0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_wd", mem_wd0, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    mem0[8] = 32'hF022_3344;
    issue("lb",  0, 0, 2'b00, 1, 32'h23, 32'h0, 32'hFFFF_FFF0, 0, 2, 0);
    issue("lbu", 0, 0, 2'b00, 0, 32'h23, 32'h0, 32'h0000_00F0, 0, 2, 0);

    mem0[8] = 32'h1122_3344;
    issue("sb", 0, 1, 2'b00, 0, 32'h21, 32'hDEAD_BEAB, 32'h0000_00F0, 0, 3, 2);
    check("sb_wd", mem_wd0, 32'h1122_AB44);
    check("sb_mem", mem0[8], 32'h1122_AB44);
    mem0[8] = 32'h1122_3344;
    issue("sh", 0, 1, 2'b01, 0, 32'h22, 32'h0000_BEEF, 32'h0000_00F0, 0, 3, 2);
    check("sh_mem", mem0[8], 32'hBEEF_3344);
    issue("lh", 0, 0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF_BEEF, 0, 2, 0);
    issue("lhu", 0, 0, 2'b01, 0, 32'h20, 32'h0, 32'h0000_3344, 0, 2, 0);

    issue("lw_mis", 0, 0, 2'b10, 0, 32'h22, 32'h0, 32'h0000_3344, 1, 1, 0);
    issue("sh_mis", 0, 1, 2'b01, 0, 32'h21, 32'h1234_5678, 32'h0000_3344, 1, 1, 0);
    issue("sz3_mis", 0, 1, 2'b11, 0, 32'h20, 32'h1234_5678, 32'h0000_3344, 1, 1, 0);
    check("mis_mem", mem0[8], 32'hBEEF_3344);

    // Reset landing between edges while the sub-word store is in WRITE.
    @(negedge clk);
    drive(0, 1, 2'b00, 0, 32'h20, 32'h0000_0077);
    @(posedge clk); #1; req0 = 1'b0;
    @(posedge clk); #2;
    check("wr_we_before_rst", {31'h0, mem_we0}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_we_async", {31'h0, mem_we0}, 32'h0);
    check("rst_busy_async", {31'h0, busy0}, 32'h0);
    @(posedge clk); #1;
    check("rst_mem_kept", mem0[8], 32'hBEEF_3344);
    check("rst_rdata_clr", rdata0, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Back-to-back: req held through busy; lw taken in the IDLE cycle after done.
    @(negedge clk);
    drive(0, 1, 2'b10, 0, 32'h20, 32'h55AA_55AA);
    q.push_back('{"b2b_sw", 32'h0, 1'b0, 2, 1, cyc + 1});
    q.push_back('{"b2b_lw", 32'h55AA_55AA, 1'b0, 2, 0, cyc + 4});
    @(posedge clk); #1;
    drive(0, 0, 2'b10, 0, 32'h20, 32'h0);
    repeat (3) @(posedge clk);
    #1; req0 = 1'b0;
    wait_empty("b2b");

    // Extra req pulsed during busy must be dropped.
    mem0[9] = 32'h0;
    @(negedge clk);
    drive(0, 1, 2'b00, 0, 32'h20, 32'h0000_0011);
    q.push_back('{"sb_pulse", 32'h55AA_55AA, 1'b0, 3, 2, cyc + 1});
    @(posedge clk); #1; req0 = 1'b0;
    @(negedge clk);
    drive(0, 1, 2'b10, 0, 32'h24, 32'hCAFE_F00D);
    @(posedge clk); #1; req0 = 1'b0;
    wait_empty("sb_pulse");
    repeat (4) @(negedge clk);
    check("pulse_no_write", mem0[9], 32'h0);
    check("pulse_sb_mem", mem0[8], 32'h55AA_5511);

    mem1[8] = 32'h1122_3344;
    issue("be_lb", 1, 0, 2'b00, 0, 32'h20, 32'h0, 32'h0000_0011, 0, 2, 0);
    issue("be_sb", 1, 1, 2'b00, 0, 32'h23, 32'h0000_00AB, 32'h0000_0011, 0, 3, 2);
    check("be_sb_mem", mem1[8], 32'h1122_33AB);
    issue("be_lh", 1, 0, 2'b01, 1, 32'h22, 32'h0, 32'h0000_33AB, 0, 2, 0);
    issue("be_lhs", 1, 0, 2'b01, 1, 32'h20, 32'h0, 32'h0000_1122, 0, 2, 0);
    check("le_untouched", mem0[8], 32'h55AA_5511);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
